// File: rtl/keypad_dir_scanner.sv
// rtl/keypad_dir_scanner.sv - 4x4 keypad column scanner decoding four direction keys
// Scans columns, debounces press and release of the first mapped key found, reports its direction.
module keypad_dir_scanner #(
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [1:0] dir,
    output logic       dir_valid,
    output logic       key_held
);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] DEBOUNCE_END = 16'(DEBOUNCE_CYCLES);

    state_t      state_q, state_d;
    logic [1:0]  col_idx_q, col_idx_d;
    logic [1:0]  row_idx_q, row_idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  dir_q, dir_d;
    logic        dir_valid_q, dir_valid_d;
    logic        key_held_q, key_held_d;

    logic [3:0]  map_mask;
    logic [3:0]  hits;
    logic        row_low;
    logic [15:0] cnt_inc;
    logic [1:0]  first_hit;
    logic [1:0]  key_code;

    // Rows that carry a direction key in the currently driven column.
    always_comb begin
        map_mask = 4'b0000;
        case (col_idx_q)
            2'd0:    map_mask = 4'b0010;
            2'd1:    map_mask = 4'b0101;
            2'd2:    map_mask = 4'b0010;
            default: map_mask = 4'b0000;
        endcase
    end

    assign hits    = ~row_n & map_mask;
    assign row_low = ~row_n[row_idx_q];
    assign cnt_inc = cnt_q + 16'd1;

    always_comb begin
        first_hit = 2'd3;
        if (hits[0])      first_hit = 2'd0;
        else if (hits[1]) first_hit = 2'd1;
        else if (hits[2]) first_hit = 2'd2;
    end

    always_comb begin
        key_code = 2'd3;
        case ({col_idx_q, row_idx_q})
            4'b0100: key_code = 2'd0;
            4'b0110: key_code = 2'd1;
            4'b0001: key_code = 2'd2;
            default: key_code = 2'd3;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        dir_valid_d = 1'b0;
        key_held_d  = key_held_q;
        case (state_q)
            SCAN: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d = 16'd0;
                    if (|hits) begin
                        state_d   = DEBOUNCE;
                        row_idx_d = first_hit;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DEBOUNCE: begin
                if (!row_low) begin
                    state_d   = SCAN;
                    col_idx_d = col_idx_q + 2'd1;
                    cnt_d     = 16'd0;
                end else if (cnt_inc == DEBOUNCE_END) begin
                    state_d     = HELD;
                    cnt_d       = 16'd0;
                    dir_d       = key_code;
                    dir_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HELD: begin
                // Release counter restarts on any low reading of the captured row.
                if (row_low) begin
                    cnt_d = 16'd0;
                end else if (cnt_inc == DEBOUNCE_END) begin
                    state_d    = SCAN;
                    col_idx_d  = col_idx_q + 2'd1;
                    cnt_d      = 16'd0;
                    key_held_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d   = SCAN;
                col_idx_d = 2'd0;
                cnt_d     = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SCAN;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            cnt_q       <= 16'd0;
            dir_q       <= 2'd0;
            dir_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            dir_valid_q <= dir_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col_n     = ~(4'b0001 << col_idx_q);
    assign dir       = dir_q;
    assign dir_valid = dir_valid_q;
    assign key_held  = key_held_q;

endmodule
